// File: rtl/name_entry_responder.sv
// Keyboard name entry responder for the pregame username handshake.
// Edits a fixed-length name into the name store and acknowledges end of entry.
module name_entry_responder #(
  parameter int NAME_LEN      = 8,
  parameter int IDX_W         = 3,
  parameter int CONFIRM_DELAY = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       user_name_req,
  input  logic             key_valid,
  input  logic [7:0]       key_char,
  output logic             name_we,
  output logic             name_player,
  output logic [IDX_W-1:0] name_idx,
  output logic [7:0]       name_char,
  output logic [3:0]       cursor,
  output logic             prompt_active,
  output logic             name_done,
  output logic             end_confirm
);

  localparam int CW = (CONFIRM_DELAY > 1) ? $clog2(CONFIRM_DELAY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDIT,
    S_PAD,
    S_DONE,
    S_WAIT,
    S_ACK,
    S_REL
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cursor_q, cursor_d;
  logic             player_q, player_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       char_q, char_d;
  logic             done_q, done_d;
  logic             conf_q, conf_d;
  logic             prompt_q, prompt_d;

  logic full, empty, printable, is_bs, is_enter, end_req;

  assign full      = cursor_q == 4'(NAME_LEN);
  assign empty     = cursor_q == 4'd0;
  assign printable = key_char >= 8'h20 && key_char <= 8'h7E;
  assign is_bs     = key_char == 8'h08;
  assign is_enter  = key_char == 8'h0D;
  assign end_req   = user_name_req == 2'b01;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cursor_q <= '0;
      player_q <= 1'b0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      idx_q    <= '0;
      char_q   <= '0;
      done_q   <= 1'b0;
      conf_q   <= 1'b0;
      prompt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      player_q <= player_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      idx_q    <= idx_d;
      char_q   <= char_d;
      done_q   <= done_d;
      conf_q   <= conf_d;
      prompt_q <= prompt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    player_d = player_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        unique case (user_name_req)
          2'b10: begin
            state_d  = S_EDIT;
            player_d = 1'b0;
            cursor_d = '0;
          end
          2'b11: begin
            state_d  = S_EDIT;
            player_d = 1'b1;
            cursor_d = '0;
          end
          2'b01: begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
          default: ;
        endcase
      end
      S_EDIT: begin
        if (key_valid) begin
          if (printable && !full) cursor_d = cursor_q + 4'd1;
          else if (is_bs && !empty) cursor_d = cursor_q - 4'd1;
          else if (is_enter && !empty) state_d = S_PAD;
        end
      end
      S_PAD: begin
        if (full) state_d = S_DONE;
        else cursor_d = cursor_q + 4'd1;
      end
      S_DONE: begin
        state_d  = S_IDLE;
        cursor_d = '0;
      end
      S_WAIT: begin
        if (!end_req) state_d = S_IDLE;
        else if (cnt_q == CW'(CONFIRM_DELAY - 1)) state_d = S_ACK;
        else cnt_d = cnt_q + 1'b1;
      end
      S_ACK: state_d = S_REL;
      // Hold off until the request drops so one end request yields one confirm.
      S_REL: if (!end_req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    we_d   = 1'b0;
    idx_d  = '0;
    char_d = '0;
    if (state_q == S_EDIT && key_valid && printable && !full) begin
      we_d   = 1'b1;
      idx_d  = IDX_W'(cursor_q);
      char_d = key_char;
    end else if (state_q == S_EDIT && key_valid && is_bs && !empty) begin
      we_d   = 1'b1;
      idx_d  = IDX_W'(cursor_q - 4'd1);
      char_d = 8'h20;
    end else if (state_q == S_PAD && !full) begin
      we_d   = 1'b1;
      idx_d  = IDX_W'(cursor_q);
      char_d = 8'h20;
    end
    done_d   = state_d == S_DONE;
    conf_d   = state_d == S_ACK;
    prompt_d = state_d == S_EDIT;
  end

  assign name_we       = we_q;
  assign name_player   = player_q;
  assign name_idx      = idx_q;
  assign name_char     = char_q;
  assign cursor        = cursor_q;
  assign prompt_active = prompt_q;
  assign name_done     = done_q;
  assign end_confirm   = conf_q;

endmodule

// File: tb/tb_name_entry_responder.sv
// Bench for name_entry_responder: directed cases plus random sessions
// checked every cycle against a behavioural model.
module tb_name_entry_responder;

  localparam int N = 8;
  localparam int IW = 3;
  localparam int D = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    user_name_req = 2'b00;
  logic          key_valid = 1'b0;
  logic [7:0]    key_char = 8'h00;
  logic          name_we, name_player, prompt_active, name_done, end_confirm;
  logic [IW-1:0] name_idx;
  logic [7:0]    name_char;
  logic [3:0]    cursor;

  name_entry_responder #(.NAME_LEN(N), .IDX_W(IW), .CONFIRM_DELAY(D)) dut (
    .clock(clock), .reset(reset), .user_name_req(user_name_req),
    .key_valid(key_valid), .key_char(key_char), .name_we(name_we),
    .name_player(name_player), .name_idx(name_idx), .name_char(name_char),
    .cursor(cursor), .prompt_active(prompt_active), .name_done(name_done),
    .end_confirm(end_confirm)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: phases named after the handshake steps.
  localparam int IDLE = 0, EDIT = 1, PAD = 2, DONE = 3;
  localparam int WAIT = 4, ACK = 5, REL = 6;
  int   m_phase = IDLE;
  int   m_len = 0;
  int   m_who = 0;
  int   m_held = 0;
  bit   e_we = 0, e_done = 0, e_conf = 0;
  int   e_idx = 0, e_char = 0;

  task automatic m_write(input int i, input int c);
    e_we = 1; e_idx = i; e_char = c;
  endtask

  always @(posedge clock or posedge reset) begin
    cyc++;
    e_we = 0; e_idx = 0; e_char = 0;
    if (reset) begin
      m_phase = IDLE; m_len = 0; m_who = 0; m_held = 0;
    end else begin
      case (m_phase)
        IDLE: begin
          if (user_name_req[1]) begin
            m_phase = EDIT; m_who = int'(user_name_req[0]); m_len = 0;
          end else if (user_name_req == 2'b01) begin
            m_phase = WAIT; m_held = 1;
          end
        end
        EDIT: if (key_valid) begin
          if (key_char >= 8'h20 && key_char <= 8'h7E) begin
            if (m_len < N) begin m_write(m_len, key_char); m_len++; end
          end else if (key_char == 8'h08) begin
            if (m_len > 0) begin m_len--; m_write(m_len, 8'h20); end
          end else if (key_char == 8'h0D) begin
            if (m_len > 0) m_phase = PAD;
          end
        end
        PAD: begin
          if (m_len == N) m_phase = DONE;
          else begin m_write(m_len, 8'h20); m_len++; end
        end
        DONE: begin m_phase = IDLE; m_len = 0; end
        WAIT: begin
          if (user_name_req != 2'b01) m_phase = IDLE;
          else if (m_held == D) m_phase = ACK;
          else m_held++;
        end
        ACK: m_phase = REL;
        default: if (user_name_req != 2'b01) m_phase = IDLE;
      endcase
    end
    e_done = m_phase == DONE;
    e_conf = m_phase == ACK;
  end

  // Observed name store and event log, captured from the DUT outputs.
  logic [7:0] store[2][N];
  int wlog[$];
  int done_cnt = 0, done_cyc = 0, conf_cnt = 0, conf_cyc = 0, last_wr = 0;

  always @(negedge clock) begin
    chk("we", name_we, e_we);
    chk("cursor", cursor, m_len);
    chk("prompt", prompt_active, m_phase == EDIT);
    chk("done", name_done, e_done);
    chk("confirm", end_confirm, e_conf);
    chk("player", name_player, m_who);
    if (e_we) begin
      chk("idx", name_idx, e_idx);
      chk("char", name_char, e_char);
    end
    if (name_we) begin
      store[name_player][name_idx] = name_char;
      wlog.push_back(int'(name_player) * 4096 + int'(name_idx) * 256 + int'(name_char));
      last_wr = cyc;
    end
    if (name_done) begin done_cnt++; done_cyc = cyc; end
    if (end_confirm) begin conf_cnt++; conf_cyc = cyc; end
  end

  function automatic int wr(input int p, input int i, input int c);
    return p * 4096 + i * 256 + c;
  endfunction

  function automatic logic [63:0] name_of(input int p);
    logic [63:0] v = '0;
    for (int i = 0; i < N; i++) v = {v[55:0], store[p][i]};
    return v;
  endfunction

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic req_pulse(input logic [1:0] r);
    user_name_req = r;
    tick;
    user_name_req = 2'b00;
  endtask

  task automatic key(input logic [7:0] c);
    key_valid = 1'b1;
    key_char = c;
    tick;
    key_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin tick; n++; end
    chk("done_timeout", done_cnt != d0, 1);
  endtask

  task automatic cmp_log(input string nm, input int base, input int exp[$]);
    chk({nm, "_count"}, wlog.size() - base, exp.size());
    for (int i = 0; i < exp.size() && base + i < wlog.size(); i++)
      chk(nm, wlog[base + i], exp[i]);
  endtask

  function automatic logic [7:0] rand_key();
    int s = $urandom_range(0, 9);
    if (s < 6) return 8'($urandom_range(32, 126));
    if (s < 8) return 8'h08;
    if (s == 8) return 8'h0D;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    int base, c0, samp;
    int exp[$];

    repeat (3) @(posedge clock);
    #2;
    chk("reset_outputs", {name_we, name_player, name_idx, name_char, cursor,
        prompt_active, name_done, end_confirm}, '0);
    reset = 1'b0;
    tick;

    // Player 1: "ABC" then Enter, padded to full length.
    base = wlog.size();
    req_pulse(2'b10);
    key(8'h41); key(8'h42); key(8'h43); key(8'h0D);
    wait_done(20);
    exp = {wr(0, 0, 8'h41), wr(0, 1, 8'h42), wr(0, 2, 8'h43)};
    for (int i = 3; i < N; i++) exp.push_back(wr(0, i, 8'h20));
    cmp_log("p1_writes", base, exp);
    chk("p1_done_latency", done_cyc - last_wr, 1);
    chk("p1_cursor_after", cursor, 0);
    chk("p1_name", name_of(0), "ABC     ");

    // Player 2 with backspaces, the second one on an empty name.
    base = wlog.size();
    req_pulse(2'b11);
    key(8'h58); key(8'h08); key(8'h08); key(8'h59); key(8'h0D);
    wait_done(20);
    exp = {wr(1, 0, 8'h58), wr(1, 0, 8'h20), wr(1, 0, 8'h59)};
    for (int i = 1; i < N; i++) exp.push_back(wr(1, i, 8'h20));
    cmp_log("p2_writes", base, exp);
    chk("p2_name", name_of(1), "Y       ");

    // Empty Enter rejected, overflow key dropped, no padding when full.
    base = wlog.size();
    req_pulse(2'b10);
    key(8'h0D);
    tick; tick;
    chk("empty_enter_prompt", prompt_active, 1);
    chk("empty_enter_cursor", cursor, 0);
    for (int i = 0; i < 9; i++) key(8'h41 + 8'(i));
    chk("full_cursor", cursor, N);
    key(8'h0D);
    wait_done(6);
    chk("full_writes", wlog.size() - base, N);
    chk("full_name", name_of(0), "ABCDEFGH");

    // End request held 20 cycles: one confirm, 16 cycles after sampling.
    c0 = conf_cnt;
    user_name_req = 2'b01;
    samp = cyc + 1;
    repeat (20) tick;
    user_name_req = 2'b00;
    repeat (3) tick;
    chk("confirm_count", conf_cnt - c0, 1);
    chk("confirm_delay", conf_cyc - samp, D);

    // Short end request, then a 10 pulse while waiting: both lost.
    c0 = conf_cnt;
    user_name_req = 2'b01;
    repeat (5) tick;
    req_pulse(2'b10);
    repeat (4) tick;
    chk("short_end_confirm", conf_cnt - c0, 0);
    chk("short_end_prompt", prompt_active, 0);

    // Reset mid-entry abandons the name.
    req_pulse(2'b10);
    key(8'h41); key(8'h42); key(8'h43);
    reset = 1'b1;
    #1;
    chk("midreset_outputs", {name_we, name_player, name_idx, name_char, cursor,
        prompt_active, name_done, end_confirm}, '0);
    tick;
    reset = 1'b0;
    tick;
    base = wlog.size();
    c0 = done_cnt;
    key(8'h51); key(8'h52); key(8'h0D);
    repeat (N + 4) tick;
    chk("postreset_writes", wlog.size() - base, 0);
    chk("postreset_done", done_cnt - c0, 0);

    // Random sessions.
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 3) != 0) begin
        req_pulse($urandom_range(0, 1) ? 2'b11 : 2'b10);
        repeat ($urandom_range(0, 14)) begin
          if ($urandom_range(0, 3) != 0) key(rand_key());
          else tick;
        end
        key(8'h5A);
        key(8'h0D);
        repeat (N + 4) tick;
      end else begin
        user_name_req = 2'b01;
        repeat ($urandom_range(1, 22)) begin
          key_valid = 1'($urandom_range(0, 1));
          key_char = rand_key();
          tick;
        end
        key_valid = 1'b0;
        user_name_req = 2'b00;
        repeat (3) tick;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/name_entry_responder.md
Name: name_entry_responder

Overview:
- View-side responder to the pregame controller's username handshake.
- Watches `user_name_req` and runs keyboard name entry for player 1 or player 2, with editing.
- Writes the name characters into the name store, then returns `name_done`, which the controller consumes as its view callback.
- Answers the end-of-entry request (`user_name_req`=01) with a delayed `end_confirm` pulse, which the controller consumes as its end-confirmed callback.

Parameters:
- NAME_LEN, 8: characters per name, range 2..15. The name store is always filled to exactly this length.
- IDX_W, 3: width of `name_idx`; must equal ceil(log2(NAME_LEN)).
- CONFIRM_DELAY, 16: cycles `user_name_req`=01 must be held before `end_confirm` fires; ≥1.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- user_name_req  in  2  00 none, 10 player-1 name, 11 player-2 name, 01 end of entry
- key_valid  in  1  one-cycle strobe: `key_char` is valid
- key_char  in  8  ASCII key code
- name_we  out  1  name-store write enable
- name_player  out  1  store select: 0 = player 1, 1 = player 2
- name_idx  out  IDX_W  character index of the write
- name_char  out  8  character written
- cursor  out  4  characters entered so far, 0..NAME_LEN
- prompt_active  out  1  high while in EDIT; view shows the prompt
- name_done  out  1  one-cycle pulse: name committed
- end_confirm  out  1  one-cycle pulse: end acknowledged

Behaviour:
- **Reset.** One clock; `reset` is asynchronous and active-high. While reset is asserted:
  - state=IDLE;
  - every output is 0, including `cursor`;
  - the delay counter is 0.
  - Reset mid-operation abandons any partial name with no further writes.
- **Output timing.** All outputs are registered. Each write (`name_we`=1 with `name_player`/`name_idx`/`name_char`) lasts exactly one cycle.
- **IDLE:**
  - `user_name_req`=10 → EDIT, with `name_player`=0 and `cursor`=0.
  - 11 → EDIT, with `name_player`=1 and `cursor`=0.
  - 01 → END_WAIT, with counter=0.
  - 00 → stay in IDLE.
  - `key_valid` is ignored.
- **EDIT.** `prompt_active`=1. `user_name_req` is ignored. On `key_valid`:
  - **Printable key** (0x20..0x7E) with `cursor`<NAME_LEN: next cycle writes `name_idx`=`cursor`, `name_char`=`key_char`; `cursor`++.
  - **Printable key** with `cursor`=NAME_LEN: dropped, no write.
  - **Backspace** (0x08) with `cursor`>0: next cycle writes 0x20 at `name_idx`=`cursor`-1; `cursor`--.
  - **Backspace** with `cursor`=0: ignored.
  - **Enter** (0x0D) with `cursor`≥1: → PAD.
  - **Enter** with `cursor`=0: ignored; empty names are rejected.
  - **Any other code:** ignored.
  - Only one key is processed per cycle. A strobe arriving on the same cycle as the previous key's write is processed normally.
- **PAD:**
  - Each cycle writes 0x20 at `name_idx`=`cursor` and increments `cursor`, until `cursor`=NAME_LEN.
  - → DONE when `cursor`=NAME_LEN; this includes entry into PAD with `cursor` already at NAME_LEN, which produces zero pad writes.
  - `key_valid` is ignored.
- **DONE:**
  - `name_done`=1 for one cycle.
  - `cursor`=0 and `prompt_active`=0 on exit.
  - → IDLE.
- **END_WAIT:**
  - The counter increments each cycle while `user_name_req`=01.
  - When the counter reaches CONFIRM_DELAY-1 → END_ACK.
  - If `user_name_req`≠01 first: → IDLE with no pulse.
- **END_ACK:**
  - `end_confirm`=1 for one cycle.
  - → END_RELEASE.
- **END_RELEASE:**
  - Stay until `user_name_req`≠01, then → IDLE.
  - This prevents a second confirm while the controller's registered request is still decaying.
- **Request width.** `user_name_req` is treated as a one-cycle pulse for 10/11 and a held level for 01. Only values sampled in IDLE are acted on; requests arriving in any other state are lost by design.

Test Plan:
- Reset mid-EDIT after 3 chars → all outputs 0 immediately. Subsequent keys cause no writes until a new 10 arrives.
- 10 pulse; keys 'A','B','C'; Enter → writes (p0,0,'A'),(p0,1,'B'),(p0,2,'C'), then pads idx 3..7 with 0x20 on consecutive cycles. `name_done` pulses 1 cycle after the idx-7 write; `cursor` ends at 0.
- 11 pulse; 'X',0x08,0x08,'Y',Enter → writes (p1,0,'X'),(p1,0,0x20),(p1,0,'Y'). The second backspace is ignored. Pads 1..7, then `name_done`.
- 10 pulse; Enter at `cursor`=0 → no transition. Then 9 printable keys → 8 writes with the 9th dropped; Enter → no pad writes, `name_done` next cycle.
- 01 held 20 cycles (CONFIRM_DELAY=16) → exactly one `end_confirm` pulse, 16 cycles after 01 is first sampled in IDLE. Dropping to 00 → IDLE.
- 01 held 5 cycles then 00 → no `end_confirm`, back in IDLE. A 10 pulse arriving during END_WAIT is ignored.
